// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: EX-stage sequencer for the M-extension units.
// Latches a muldiv request, drives the external multiplier/divider,
// resolves divide corner cases locally, reuses the last divide result
// for a matching DIV<->REM pair, and holds the pipeline until done.
module muldiv_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter bit          CACHE_EN    = 1'b1,
  parameter bit          SHORTCUT_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sel_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] opa_o,
  output logic [XLEN-1:0] opb_o,
  output logic            mul_start_o,
  output logic [1:0]      mul_op_o,
  input  logic            mul_done_i,
  input  logic [XLEN-1:0] mul_result_i,
  output logic            div_start_o,
  output logic            div_signed_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_quo_i,
  input  logic [XLEN-1:0] div_rem_i,
  output logic            kill_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_e          state_q, state_d;
  logic            first_q;
  logic [XLEN-1:0] opa_q, opb_q, result_q;
  logic [1:0]      op_q;
  logic            signed_q;

  logic            cache_valid_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_quo_q, cache_rem_q;
  logic            cache_signed_q;

  logic            accept, req_signed, req_rem;
  logic            div_by_zero, div_overflow, shortcut_hit, cache_hit, local_hit;
  logic            unit_done;
  logic [XLEN-1:0] local_result, unit_result;

  // Request decode: accepted only from IDLE and never while flushing.
  assign accept       = (state_q == ST_IDLE) & start_i & ~flush_i;
  assign req_signed   = ~op_i[0];
  assign req_rem      = op_i[1];
  assign div_by_zero  = (rs2_i == '0);
  assign div_overflow = req_signed & (rs1_i == INT_MIN) & (rs2_i == ALL_ONES);
  assign shortcut_hit = SHORTCUT_EN & (div_by_zero | div_overflow);
  assign cache_hit    = CACHE_EN & cache_valid_q & (cache_rs1_q == rs1_i) &
                        (cache_rs2_q == rs2_i) & (cache_signed_q == req_signed);
  assign local_hit    = shortcut_hit | cache_hit;

  // A unit result is only taken in its own BUSY state and flush always wins.
  assign unit_done = ~flush_i & (((state_q == ST_MUL_BUSY) & mul_done_i) |
                                 ((state_q == ST_DIV_BUSY) & div_done_i));
  assign unit_result = (state_q == ST_MUL_BUSY) ? mul_result_i :
                       (op_q[1] ? div_rem_i : div_quo_i);

  // Locally resolved divide result: corner-case shortcut first, else cached pair.
  always_comb begin
    local_result = '0;
    if (shortcut_hit) begin
      if (div_by_zero) local_result = req_rem ? rs1_i : ALL_ONES;
      else             local_result = req_rem ? '0 : INT_MIN;
    end else begin
      local_result = req_rem ? cache_rem_q : cache_quo_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!sel_i)        state_d = ST_MUL_BUSY;
          else if (local_hit) state_d = ST_DONE;
          else               state_d = ST_DIV_BUSY;
        end
      end
      ST_MUL_BUSY: begin
        if (flush_i)         state_d = ST_IDLE;
        else if (mul_done_i) state_d = ST_DONE;
      end
      ST_DIV_BUSY: begin
        if (flush_i)         state_d = ST_IDLE;
        else if (div_done_i) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; the IDLE stall term is gated by reset so everything reads 0 in reset.
  always_comb begin
    stall_o     = 1'b0;
    mul_start_o = 1'b0;
    div_start_o = 1'b0;
    kill_o      = 1'b0;
    valid_o     = 1'b0;
    case (state_q)
      ST_IDLE:     stall_o = reset_i & start_i & ~flush_i;
      ST_MUL_BUSY: begin
        stall_o     = 1'b1;
        mul_start_o = first_q & ~flush_i;
        kill_o      = flush_i;
      end
      ST_DIV_BUSY: begin
        stall_o     = 1'b1;
        div_start_o = first_q & ~flush_i;
        kill_o      = flush_i;
      end
      ST_DONE:     valid_o = ~flush_i;
      default:     ;
    endcase
  end

  // Operand/op latching on accept and result capture on completion.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      first_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      signed_q <= 1'b0;
      result_q <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        opa_q    <= rs1_i;
        opb_q    <= rs2_i;
        op_q     <= op_i;
        signed_q <= req_signed;
      end
      if (accept & sel_i & local_hit) result_q <= local_result;
      else if (unit_done)             result_q <= unit_result;
    end
  end

  // Last-divide cache: filled only by a divider completion that was not flushed.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cache_valid_q  <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_signed_q <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else if (CACHE_EN && (state_q == ST_DIV_BUSY) && div_done_i && !flush_i) begin
      cache_valid_q  <= 1'b1;
      cache_rs1_q    <= opa_q;
      cache_rs2_q    <= opb_q;
      cache_signed_q <= signed_q;
      cache_quo_q    <= div_quo_i;
      cache_rem_q    <= div_rem_i;
    end
  end

  assign opa_o        = opa_q;
  assign opb_o        = opb_q;
  assign mul_op_o     = op_q;
  assign div_signed_o = signed_q;
  assign result_o     = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: behavioural multiplier/divider units,
// a driver that issues requests and pushes expected results into a queue,
// and a monitor that pops and compares on every valid_o.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, sel_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [31:0] opa_o, opb_o, result_o;
  logic        mul_start_o, div_start_o, div_signed_o, kill_o, stall_o, valid_o;
  logic [1:0]  mul_op_o;
  logic        mul_done_i, div_done_i;
  logic [31:0] mul_result_i, div_quo_i, div_rem_i;

  always #5 clk_i = ~clk_i;

  muldiv_sequencer #(.XLEN(32), .CACHE_EN(1'b1), .SHORTCUT_EN(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .sel_i(sel_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .opa_o(opa_o), .opb_o(opb_o),
    .mul_start_o(mul_start_o), .mul_op_o(mul_op_o), .mul_done_i(mul_done_i),
    .mul_result_i(mul_result_i), .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_done_i(div_done_i), .div_quo_i(div_quo_i), .div_rem_i(div_rem_i),
    .kill_o(kill_o), .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          mul_lat = 1;
  int          div_lat = 1;
  // Reference view of the last completed division (operands + signedness).
  bit          c_valid = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;
  bit          c_s = 1'b0;
  int          txn_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // RISC-V multiply semantics from sign/zero-extended 64-bit products.
  function automatic logic [31:0] mul_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // RISC-V divide semantics including zero divisor and signed overflow.
  function automatic logic [31:0] div_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    longint      sa, sb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else if (!op[0]) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Multiplier unit: done mul_lat cycles after the start pulse, aborts on kill/reset.
  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    int          lat;
    bit          ab;
    mul_done_i = 1'b0; mul_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (mul_start_o) begin
        a = opa_o; b = opb_o; op = mul_op_o; lat = mul_lat;
        ab = kill_o || !reset_i;
        for (int i = 1; i < lat && !ab; i++) begin
          @(negedge clk_i);
          ab = kill_o || !reset_i;
        end
        if (!ab) begin
          @(posedge clk_i); #1;
          mul_done_i = 1'b1; mul_result_i = mul_ref(op, a, b);
          @(posedge clk_i); #1;
          mul_done_i = 1'b0; mul_result_i = $urandom();
        end
      end
    end
  end

  // Divider unit: done div_lat cycles after the start pulse, aborts on kill/reset.
  initial begin
    logic [31:0] a, b;
    bit          s, ab;
    int          lat;
    longint      sa, sb;
    div_done_i = 1'b0; div_quo_i = '0; div_rem_i = '0;
    forever begin
      @(negedge clk_i);
      if (div_start_o) begin
        a = opa_o; b = opb_o; s = div_signed_o; lat = div_lat;
        ab = kill_o || !reset_i;
        for (int i = 1; i < lat && !ab; i++) begin
          @(negedge clk_i);
          ab = kill_o || !reset_i;
        end
        if (!ab) begin
          @(posedge clk_i); #1;
          div_done_i = 1'b1;
          if (b == 32'h0) begin
            div_quo_i = 32'hFFFF_FFFF; div_rem_i = a;
          end else if (s) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            div_quo_i = 32'(sa / sb); div_rem_i = 32'(sa % sb);
          end else begin
            div_quo_i = a / b; div_rem_i = a % b;
          end
          @(posedge clk_i); #1;
          div_done_i = 1'b0; div_quo_i = $urandom(); div_rem_i = $urandom();
        end
      end
    end
  end

  // Monitor: every valid_o must match the oldest outstanding expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (reset_i === 1'b1 && valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_o), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("result", result_o, e);
        end
      end
    end
  end

  // Issue one request. mode 0: runs to completion; 1: flush while the unit is busy;
  // 2: flush in the result cycle. Entered and left just after a rising edge.
  task automatic run_txn(input bit sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int mode_in);
    logic [31:0] exp_res;
    bit          sgn, shortcut, hit, unit_path, fin;
    int          mode, exp_lat, fc, cyc, vcyc, stalls, ms, ds, kills;
    mode      = mode_in;
    sgn       = ~op[0];
    shortcut  = sel && (b == 32'h0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit       = sel && c_valid && c_a == a && c_b == b && c_s == sgn;
    unit_path = !sel || !(shortcut || hit);
    exp_res   = sel ? div_ref(op, a, b) : mul_ref(op, a, b);
    exp_lat   = unit_path ? lat + 2 : 1;
    if (mode == 1 && !unit_path) mode = 2;
    if (mode == 1)      fc = int'($urandom_range(lat + 1, 2));
    else if (mode == 2) fc = exp_lat;
    else                fc = -1;
    if (sel) div_lat = lat; else mul_lat = lat;
    if (mode == 0) exp_q.push_back(exp_res);
    if (sel && unit_path && mode != 1) begin
      c_valid = 1'b1; c_a = a; c_b = b; c_s = sgn;
    end
    $display("txn %0d: sel=%0d op=%0d a=%08h b=%08h lat=%0d mode=%0d expect=%08h path=%s",
             txn_id, sel, op, a, b, lat, mode, exp_res, unit_path ? "unit" : "local");
    txn_id++;
    start_i = 1'b1; sel_i = sel; op_i = op; rs1_i = a; rs2_i = b;
    cyc = 0; vcyc = -1; stalls = 0; ms = 0; ds = 0; kills = 0; fin = 1'b0;
    while (!fin && cyc < 64) begin
      flush_i = (cyc == fc);
      @(negedge clk_i);
      stalls += int'(stall_o);
      ms     += int'(mul_start_o);
      ds     += int'(div_start_o);
      kills  += int'(kill_o);
      if (valid_o) begin vcyc = cyc; fin = 1'b1; end
      if (cyc == fc) fin = 1'b1;
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0; flush_i = 1'b0;
    check("mul_start_pulses", 32'(ms), 32'((!sel && unit_path) ? 1 : 0));
    check("div_start_pulses", 32'(ds), 32'((sel && unit_path) ? 1 : 0));
    check("kill_pulses", 32'(kills), 32'((mode == 1) ? 1 : 0));
    if (mode == 0) check("latency", 32'(vcyc), 32'(exp_lat));
    if (mode != 1) check("stall_cycles", 32'(stalls), 32'(exp_lat));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a, b, last_a, last_b;
    bit          sel;
    logic [1:0]  op;
    int          lat, mode, mr, gap;
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd100,
             32'h7FFF_FFFF, 32'hFFFF_FFF9};
    last_a = 32'd100; last_b = 32'd7;

    reset_i = 1'b0; start_i = 1'b1; sel_i = 1'b0; op_i = 2'b00;
    rs1_i = 32'd3; rs2_i = 32'd4; flush_i = 1'b0;
    #12;
    check("reset_ctrl", {24'b0, mul_start_o, mul_op_o, div_start_o, div_signed_o,
                         kill_o, stall_o, valid_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    check("reset_opa", opa_o, 32'h0);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;

    run_txn(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, 3, 0);
    run_txn(1'b1, 2'b00, 32'd100, 32'd7, 4, 0);
    run_txn(1'b1, 2'b10, 32'd100, 32'd7, 4, 0);
    run_txn(1'b1, 2'b01, 32'd5, 32'd0, 4, 0);
    run_txn(1'b1, 2'b11, 32'd5, 32'd0, 4, 0);
    run_txn(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4, 0);
    run_txn(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4, 0);
    run_txn(1'b1, 2'b00, 32'd1000, 32'd3, 5, 1);
    run_txn(1'b1, 2'b10, 32'd1000, 32'd3, 2, 0);
    run_txn(1'b1, 2'b01, 32'd1000, 32'd3, 2, 2);
    run_txn(1'b1, 2'b00, 32'd1000, 32'd3, 2, 2);

    // A request presented together with flush must not be accepted.
    start_i = 1'b1; sel_i = 1'b1; op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd3; flush_i = 1'b1;
    @(negedge clk_i);
    check("idle_flush_stall", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("no_accept_under_flush", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;

    // Reset in the middle of a multiply: outputs clear at once, cache forgotten.
    mul_lat = 10;
    start_i = 1'b1; sel_i = 1'b0; op_i = 2'b01; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0;
    repeat (3) begin @(posedge clk_i); #1; end
    reset_i = 1'b0;
    #1;
    check("midrst_ctrl", {24'b0, mul_start_o, mul_op_o, div_start_o, div_signed_o,
                          kill_o, stall_o, valid_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_opa", opa_o, 32'h0);
    check("midrst_opb", opb_o, 32'h0);
    start_i = 1'b0;
    c_valid = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    run_txn(1'b1, 2'b10, 32'd1000, 32'd3, 2, 0);

    for (int t = 0; t < 140; t++) begin
      sel = 1'($urandom_range(1, 0));
      op  = 2'($urandom_range(3, 0));
      if (sel && $urandom_range(9, 0) < 3) begin
        a = last_a; b = last_b;
      end else begin
        a = ($urandom_range(3, 0) == 0) ? $urandom() : pool[$urandom_range(7, 0)];
        b = ($urandom_range(3, 0) == 0) ? $urandom() : pool[$urandom_range(7, 0)];
      end
      if (sel) begin last_a = a; last_b = b; end
      lat = int'($urandom_range(6, 1));
      mr  = int'($urandom_range(99, 0));
      mode = (mr < 70) ? 0 : ((mr < 85) ? 1 : 2);
      run_txn(sel, op, a, b, lat, mode);
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin @(posedge clk_i); #1; end
    end

    repeat (3) begin @(posedge clk_i); #1; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
